// File: rtl/uiq_pkg.sv
// Shared micro-op definitions for the decode unit and the issue queue.
package uiq_pkg;

    localparam int unsigned UIQ_UOP_W = 20;

    // Micro-op field positions, common with the decoder
    localparam int unsigned UOP_ALU_OP_LSB = 0;
    localparam int unsigned UOP_ALU_OP_W   = 5;
    localparam int unsigned UOP_RD_LSB     = 5;
    localparam int unsigned UOP_RS1_LSB    = 10;
    localparam int unsigned UOP_RS2_LSB    = 15;
    localparam int unsigned UOP_REG_W      = 5;

    // Width of a bundle-size field able to hold n-1 (never zero width)
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uiq_storage.sv
// Circular micro-op array: MAX_UOPS write ports at consecutive addresses from wr_base, one read port.
module uiq_storage #(
    parameter int unsigned UOP_W    = 20,
    parameter int unsigned MAX_UOPS = 3,
    parameter int unsigned DEPTH    = 8
) (
    input  logic                        clk,
    input  logic [MAX_UOPS-1:0]         wr_en,
    input  logic [$clog2(DEPTH)-1:0]    wr_base,
    input  logic [MAX_UOPS*UOP_W-1:0]   wr_data,
    input  logic [$clog2(DEPTH)-1:0]    rd_addr,
    output logic [UOP_W-1:0]            rd_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [UOP_W-1:0] mem [DEPTH];

    // Port k lands at wr_base+k; addresses wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        for (int k = 0; k < int'(MAX_UOPS); k++) begin
            if (wr_en[k]) begin
                mem[wr_base + PTR_W'(k)] <= wr_data[k*UOP_W +: UOP_W];
            end
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uop_issue_queue.sv
// Micro-op issue queue: accepts whole decoded bundles, issues one micro-op per cycle, last slot first.
// Optional same-cycle bypass for a single micro-op into an empty queue: define UIQ_BYPASS_EN.
module uop_issue_queue
    import uiq_pkg::*;
#(
    parameter int unsigned UOP_W    = UIQ_UOP_W,
    parameter int unsigned MAX_UOPS = 3,
    parameter int unsigned DEPTH    = 8
) (
    input  logic                        clk,
    input  logic                        a_rst,
    input  logic                        hold,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ack,
    input  logic [MAX_UOPS*UOP_W-1:0]   in_uop,
    input  logic [cnt_w(MAX_UOPS)-1:0]  in_count,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [UOP_W-1:0]            out_uop,
    output logic                        out_last,
    output logic [$clog2(DEPTH):0]      level
);

    localparam int unsigned CNT_W = cnt_w(MAX_UOPS);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [PTR_W-1:0]           head;
    logic [PTR_W-1:0]           tail;
    logic [DEPTH-1:0]           last_q;
    logic [LVL_W-1:0]           n_in;
    logic                       room_ok;
    logic                       bypass_c;
    logic                       enq;
    logic                       deq;
    logic [MAX_UOPS-1:0]        wr_en;
    logic [MAX_UOPS*UOP_W-1:0]  wr_data;
    logic [UOP_W-1:0]           rd_data;

    assign n_in    = LVL_W'(in_count) + LVL_W'(1);
    assign room_ok = (LVL_W'(DEPTH) - level) >= n_in;
    assign in_ack  = a_rst & in_valid & ~hold & ~flush & room_ok;

`ifdef UIQ_BYPASS_EN
    assign bypass_c = a_rst & (level == '0) & in_valid & (in_count == CNT_W'(0))
                    & out_ready & ~hold & ~flush;
    assign out_uop  = bypass_c ? in_uop[UOP_W-1:0] : rd_data;
`else
    assign bypass_c = 1'b0;
    assign out_uop  = rd_data;
`endif

    assign out_valid = bypass_c | (a_rst & (level != '0) & ~hold);
    assign out_last  = bypass_c | (out_valid & last_q[head]);

    assign enq = in_ack & ~bypass_c;
    assign deq = out_valid & out_ready & ~bypass_c;

    // Write port k takes slot (in_count - k), so slot in_count sits at the tail and issues first
    always_comb begin
        wr_en   = '0;
        wr_data = '0;
        for (int k = 0; k < int'(MAX_UOPS); k++) begin
            for (int s = 0; s < int'(MAX_UOPS); s++) begin
                if (int'(in_count) == s + k) begin
                    wr_en[k]                  = enq;
                    wr_data[k*UOP_W +: UOP_W] = in_uop[s*UOP_W +: UOP_W];
                end
            end
        end
    end

    // Pointer and occupancy state; flush wins over everything, hold freezes it
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            head  <= '0;
            tail  <= '0;
            level <= '0;
        end else if (flush) begin
            head  <= tail;
            level <= '0;
        end else begin
            if (enq) begin
                tail <= tail + PTR_W'(n_in);
            end
            if (deq) begin
                head <= head + PTR_W'(1);
            end
            level <= level + (enq ? n_in : LVL_W'(0)) - LVL_W'(deq);
        end
    end

    // Marks the entry holding slot 0, the final step of its bundle
    always_ff @(posedge clk) begin
        for (int k = 0; k < int'(MAX_UOPS); k++) begin
            if (wr_en[k]) begin
                last_q[tail + PTR_W'(k)] <= (k == int'(in_count));
            end
        end
    end

    uiq_storage #(
        .UOP_W    (UOP_W),
        .MAX_UOPS (MAX_UOPS),
        .DEPTH    (DEPTH)
    ) u_storage (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_base (tail),
        .wr_data (wr_data),
        .rd_addr (head),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_uop_issue_queue.sv
// Scoreboard bench for uop_issue_queue: directed bundle scenarios followed by randomized traffic.
module tb_uop_issue_queue;

    localparam int UOP_W    = 20;
    localparam int MAX_UOPS = 3;
    localparam int DEPTH    = 8;
`ifdef UIQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      a_rst = 1'b0;
    logic                      hold = 1'b0;
    logic                      flush = 1'b0;
    logic                      in_valid = 1'b0;
    logic                      in_ack;
    logic [MAX_UOPS*UOP_W-1:0] in_uop = '0;
    logic [1:0]                in_count = '0;
    logic                      out_valid;
    logic                      out_ready = 1'b0;
    logic [UOP_W-1:0]          out_uop;
    logic                      out_last;
    logic [3:0]                level;

    uop_issue_queue #(
        .UOP_W    (UOP_W),
        .MAX_UOPS (MAX_UOPS),
        .DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .a_rst     (a_rst),
        .hold      (hold),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ack    (in_ack),
        .in_uop    (in_uop),
        .in_count  (in_count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_uop   (out_uop),
        .out_last  (out_last),
        .level     (level)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Expected issue stream: {last, uop} in the order execute should see them
    logic [UOP_W:0] exp_q[$];
    bit             pend_ack;
    bit             pend_flush;
    int             m_sz;
    bit             e_ack, e_byp, e_ov;
    logic [UOP_W:0] e_item;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: compares DUT outputs against the reference queue away from the rising edge
    always @(negedge clk) begin
        if (!a_rst) begin
            chk("rst_out_valid", 32'(out_valid), 32'(0));
            chk("rst_in_ack",    32'(in_ack),    32'(0));
            chk("rst_out_last",  32'(out_last),  32'(0));
            chk("rst_level",     32'(level),     32'(0));
            exp_q.delete();
            pend_ack   = 1'b0;
            pend_flush = 1'b0;
        end else begin
            m_sz  = exp_q.size();
            e_ack = in_valid && !hold && !flush && (DEPTH - m_sz >= int'(in_count) + 1);
            e_byp = BYP && m_sz == 0 && in_valid && in_count == 2'd0 && out_ready && !hold && !flush;
            e_ov  = e_byp || (m_sz != 0 && !hold);
            chk("in_ack",    32'(in_ack),    32'(e_ack));
            chk("out_valid", 32'(out_valid), 32'(e_ov));
            chk("level",     32'(level),     32'(m_sz));
            if (e_ov) begin
                e_item = e_byp ? {1'b1, in_uop[UOP_W-1:0]} : exp_q[0];
                chk("out_uop",  32'(out_uop),  32'(e_item[UOP_W-1:0]));
                chk("out_last", 32'(out_last), 32'(e_item[UOP_W]));
                if (out_ready && !e_byp) begin
                    void'(exp_q.pop_front());
                end
            end
            pend_ack   = e_ack && !e_byp;
            pend_flush = flush;
        end
    end

    // Reference model update at the clock edge: flush empties, an accepted bundle appends slot in_count..0
    always @(posedge clk) begin
        if (a_rst) begin
            if (pend_flush) begin
                exp_q.delete();
            end else if (pend_ack) begin
                for (int s = int'(in_count); s >= 0; s--) begin
                    exp_q.push_back({s == 0, in_uop[s*UOP_W +: UOP_W]});
                end
            end
        end
    end

    task automatic drive(input bit v, input int cnt, input logic [UOP_W-1:0] s0,
                         input logic [UOP_W-1:0] s1, input logic [UOP_W-1:0] s2,
                         input bit rdy, input bit h, input bit f);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_count  = 2'(cnt);
        in_uop    = {s2, s1, s0};
        out_ready = rdy;
        hold      = h;
        flush     = f;
    endtask

    task automatic idle(input int n, input bit rdy);
        repeat (n) drive(1'b0, 0, '0, '0, '0, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset held for a few cycles
        repeat (3) @(posedge clk);
        #1;
        a_rst = 1'b1;

        // Three-uop bundle issues C, B, A with last on A
        drive(1'b1, 2, 20'hAAAAA, 20'hBBBBB, 20'hCCCCC, 1'b1, 1'b0, 1'b0);
        idle(5, 1'b1);

        // Fill to six, full-bundle backpressure, then one dequeue frees room
        drive(1'b1, 2, 20'h00101, 20'h00102, 20'h00103, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 2, 20'h00201, 20'h00202, 20'h00203, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 2, 20'h00301, 20'h00302, 20'h00303, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 2, 20'h00301, 20'h00302, 20'h00303, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 2, 20'h00301, 20'h00302, 20'h00303, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 2, 20'h00301, 20'h00302, 20'h00303, 1'b0, 1'b0, 1'b0);
        idle(12, 1'b1);

        // Move tail to entry 7, then a two-uop bundle wraps to entry 0
        drive(1'b1, 2, 20'h00401, 20'h00402, 20'h00403, 1'b1, 1'b0, 1'b0);
        idle(5, 1'b1);
        drive(1'b1, 1, 20'h00501, 20'h00502, 20'h00000, 1'b1, 1'b0, 1'b0);
        idle(4, 1'b1);

        // Level four, then flush together with hold and a pending bundle
        drive(1'b1, 1, 20'h00601, 20'h00602, 20'h00000, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1, 20'h00701, 20'h00702, 20'h00000, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 2, 20'h00801, 20'h00802, 20'h00803, 1'b0, 1'b1, 1'b1);
        idle(3, 1'b0);

        // Single micro-op into an empty queue
        drive(1'b1, 0, 20'h12345, 20'h00000, 20'h00000, 1'b1, 1'b0, 1'b0);
        idle(3, 1'b1);

        // Reset after B is consumed: A must never appear
        drive(1'b1, 2, 20'h0A0A0, 20'h0B0B0, 20'h0C0C0, 1'b1, 1'b0, 1'b0);
        idle(3, 1'b1);
        a_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a_rst = 1'b1;
        idle(5, 1'b1);

        // Randomized traffic with occasional hold, flush and reset
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            a_rst     = ($urandom_range(0, 299) != 0);
            in_valid  = 1'($urandom_range(0, 1));
            in_count  = 2'($urandom_range(0, MAX_UOPS - 1));
            in_uop    = 60'({$urandom, $urandom});
            out_ready = ($urandom_range(0, 3) != 0);
            hold      = ($urandom_range(0, 9) == 0);
            flush     = ($urandom_range(0, 29) == 0);
        end
        idle(1, 1'b1);
        a_rst = 1'b1;
        idle(12, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uop_issue_queue.md
UOP_ISSUE_QUEUE -- requirements
Module: uop_issue_queue

Interface
REQ-001 SHALL have parameter UOP_W, default 20, micro-op width in bits.
REQ-002 SHALL have parameter MAX_UOPS, default 3, maximum micro-ops per decoded bundle (1..4).
REQ-003 SHALL have parameter DEPTH, default 8, queue entries; a power of two, at least MAX_UOPS.
REQ-004 SHALL have port clk  input  1  single clock, all state rising-edge.
REQ-005 SHALL have port a_rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port hold  input  1  pipeline stall; freezes enqueue and dequeue.
REQ-007 SHALL have port flush  input  1  discard all queued micro-ops (PC redirect).
REQ-008 SHALL have port in_valid  input  1  decoder presents a bundle.
REQ-009 SHALL have port in_ack  output  1  bundle accepted this cycle.
REQ-010 SHALL have port in_uop  input  MAX_UOPS*UOP_W  bundle; slot i at bits [i*UOP_W +: UOP_W].
REQ-011 SHALL have port in_count  input  clog2(MAX_UOPS)  bundle size minus one (0 means one micro-op).
REQ-012 SHALL have port out_valid  output  1  a micro-op is offered to execute.
REQ-013 SHALL have port out_ready  input  1  execute consumes the offered micro-op.
REQ-014 SHALL have port out_uop  output  UOP_W  offered micro-op.
REQ-015 SHALL have port out_last  output  1  offered micro-op is slot 0, the final step of its bundle.
REQ-016 SHALL have port level  output  clog2(DEPTH)+1  occupied entries.

Function
REQ-017 in_ack SHALL equal in_valid & ~hold & ~flush & (DEPTH - level >= in_count+1), using the level registered at the start of the cycle.
REQ-018 On in_ack, all in_count+1 micro-ops SHALL be written atomically; no partial bundle is ever stored.
REQ-019 Issue order within a bundle SHALL be slot in_count first, down to slot 0 last; out_last SHALL be 1 only for slot 0.
REQ-020 out_valid SHALL equal (level != 0) & ~hold, except as modified by REQ-031.
REQ-021 A dequeue SHALL occur when out_valid & out_ready; the head pointer advances by one.
REQ-022 A simultaneous enqueue and dequeue SHALL update level by (in_count+1) - 1 in one cycle.
REQ-023 Head and tail pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH or underflow.
REQ-024 flush SHALL take priority over enqueue and dequeue: next cycle level=0, head=tail, out_valid=0.
REQ-025 A flush asserted together with hold SHALL still flush.
REQ-026 While hold=1 (no flush), pointers, level and storage SHALL be unchanged.
REQ-027 When non-bypassed, latency from in_ack to out_valid of that bundle's first micro-op SHALL be one cycle if the queue was empty.
REQ-028 out_uop SHALL be stable while out_valid=1 and out_ready=0.

Reset
REQ-029 While a_rst=0, head, tail and level SHALL be 0. out_valid, in_ack and out_last SHALL be 0. Storage contents are don't-care.
REQ-030 Reset asserted mid-bundle SHALL discard the partial bundle; no micro-op of it issues after release.

Configuration
REQ-031 With UIQ_BYPASS_EN defined, the following SHALL pass in_uop slot 0 straight to out_uop in the same cycle with out_valid=1 and out_last=1, without writing storage: level=0, in_valid=1, in_count=0, out_ready=1, ~hold, ~flush. Without UIQ_BYPASS_EN, no combinational in-to-out path SHALL exist.

Structure
REQ-032 A shared package uiq_pkg SHALL hold the UOP_W default and the micro-op field position constants (ALU op, destination, register selects) shared with the decode unit.
REQ-033 Storage SHALL be a sub-module uiq_storage. It is a DEPTH x UOP_W circular array with up to MAX_UOPS write ports at consecutive addresses and one read port.

Verification
REQ-034 Reset, then 3-uop bundle {A,B,C} with in_count=2 and out_ready=1 -> issue C,B,A on consecutive cycles, out_last only with A, level 3->0.
REQ-035 Fill to level=6 with DEPTH=8, offer 3-uop bundle, out_ready=0 -> in_ack=0. Then one dequeue -> in_ack=1 next cycle, level 5->8.
REQ-036 Tail at entry 7, enqueue 2-uop bundle -> entries 7 and 0 written, issue order correct across wrap.
REQ-037 level=4, flush=1 with in_valid=1 and hold=1 -> in_ack=0, level=0 next cycle, out_valid=0.
REQ-038 Empty queue, 1-uop bundle X, out_ready=1 -> out_uop=X same cycle with UIQ_BYPASS_EN; without it, one cycle later.
REQ-039 a_rst pulsed low after B of {A,B,C} issued -> out_valid=0 and level=0 after release; A never issued.
